gdb_rsp_tx: RTL
===============

// Module: gdb_rsp_tx
// PURPOSE
//  Hardware GDB Remote Serial Protocol packet transmitter: the reply path that pairs
//  with the stub's packet receiver. It frames a raw reply payload as $<data>#<cs>,
//  escapes reserved characters, appends the checksum as two lowercase hex digits, and
//  retransmits on NAK or ack timeout. It sits between the debug controller of the
//  NERV SoC and the byte-serial link (UART TX or socket bridge).
// PARAMETERS
//  BUF_DEPTH    256   payload bytes held for retransmission (power of 2)
//  RETRY_MAX    3     retransmissions allowed before giving up
//  ACK_TIMEOUT  4096  cycles spent in WAIT_ACK before an implicit NAK (0 = never)
// PORTS
//  clk          in   1  clock; the only clock
//  rst          in   1  synchronous reset, active-high
//  in_valid     in   1  payload beat valid
//  in_ready     out  1  payload beat accepted while in_valid && in_ready
//  in_data      in   8  raw (unescaped) payload byte
//  in_last      in   1  final beat of the payload
//  in_empty     in   1  beat carries no byte (legal only with in_last; gives "$#00")
//  out_valid    out  1  framed byte valid
//  out_ready    in   1  sink accepts the byte
//  out_data     out  8  framed byte
//  ack_valid    in   1  ack character received from host (one-cycle strobe)
//  ack_nak      in   1  1 = '-', 0 = '+'; sampled with ack_valid
//  noack        in   1  QStartNoAckMode active: skip WAIT_ACK
//  busy         out  1  state != IDLE
//  err_ovf      out  1  one-cycle pulse: payload beat dropped because the buffer is full
//  err_retry    out  1  one-cycle pulse: packet abandoned after RETRY_MAX retransmissions
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1, out_valid=0, out_data=0, busy=0, err_*=0, counters=0.
//  - Store-and-forward. LOAD (IDLE counts as LOAD): accept beats and write them to the
//    buffer; the wr pointer counts bytes. Beat accepted with in_last -> SOF next cycle.
//    in_ready=1 only in IDLE/LOAD.
//  - Overflow: beats past BUF_DEPTH are still accepted (in_ready=1) but discarded, with
//    one err_ovf pulse per dropped beat; the packet is sent truncated.
//  - Order: SOF '$' -> DATA -> EOF '#' -> CS_HI -> CS_LO -> WAIT_ACK, or -> IDLE if noack=1.
//  - Latency: out_valid=1 with '$' in the cycle after the last beat is accepted.
//  - out_data/out_valid stay stable until out_ready; advance only on valid && ready.
//  - Escape: bytes 0x23 '#', 0x24 '$', 0x2A '*', 0x7D '}' go out as 0x7D followed by
//    byte^0x20 (ESC sub-state). The rd pointer advances after the second byte.
//  - Checksum: 8-bit sum mod 256 of every byte sent between '$' and '#', escaped forms
//    included. It is cleared at SOF and recomputed on every retransmission.
//  - Hex output: CS_HI=hex(cs[7:4]), CS_LO=hex(cs[3:0]); digits '0'-'9','a'-'f'.
//  - Empty payload (wr count 0) skips DATA.
//  - WAIT_ACK: '+' -> IDLE and clear retry count. '-' or timeout -> SOF and replay from
//    buffer address 0, retry+1. If retry==RETRY_MAX on that event -> pulse err_retry,
//    go IDLE.
//  - ack_valid is ignored outside WAIT_ACK. noack is sampled on entry to CS_LO only.
//  - Reset mid-packet: out_valid=0 in the next cycle, buffer contents abandoned.
// STRUCTURE
//  - gdb_rsp_pkg (shared with the receiver): character constants (SOF, EOF, ESC, RLE,
//    ACK, NAK), ESC_XOR=8'h20, state enum, function is_reserved(byte),
//    function hex_digit(nibble).
//  - One sub-module, gdb_rsp_txbuf: BUF_DEPTH x 8 simple dual-port RAM with synchronous
//    read. The FSM prefetches so out_valid has no bubble between consecutive DATA bytes
//    while out_ready=1.
// TESTING
//  1. Payload "OK", out_ready=1 -> "$OK#9a", then '+' -> busy=0.
//  2. Single beat in_empty=1,in_last=1 -> "$#00".
//  3. Payload "a#" -> bytes 24 61 7D 03 23 65 31 ("$a}\x03#e1").
//  4. Payload "OK", then '-' -> identical "$OK#9a" resent; 4 NAKs with RETRY_MAX=3
//     -> 4 transmissions, then err_retry pulse, busy=0.
//  5. noack=1, payload "S05" -> "$S05#b8", busy=0 the cycle after the last digit;
//     a later '-' is ignored.
//  6. BUF_DEPTH=4, payload 6 x 'A' -> 2 err_ovf pulses, "$AAAA#04"; random out_ready
//     stalls keep out_data stable; rst mid-DATA -> out_valid=0 next cycle.

Source files
------------

// File: rtl/gdb_rsp_pkg.sv
// Shared GDB RSP definitions: framing characters, transmitter state encoding and
// small byte helpers used by both the packet transmitter and receiver.
package gdb_rsp_pkg;

  localparam logic [7:0] CH_SOF  = 8'h24;  // '$'
  localparam logic [7:0] CH_EOF  = 8'h23;  // '#'
  localparam logic [7:0] CH_ESC  = 8'h7D;  // '}'
  localparam logic [7:0] CH_RLE  = 8'h2A;  // '*'
  localparam logic [7:0] CH_ACK  = 8'h2B;  // '+'
  localparam logic [7:0] CH_NAK  = 8'h2D;  // '-'
  localparam logic [7:0] ESC_XOR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SOF      = 3'd2,
    ST_DATA     = 3'd3,
    ST_EOF      = 3'd4,
    ST_CS_HI    = 3'd5,
    ST_CS_LO    = 3'd6,
    ST_WAIT_ACK = 3'd7
  } tx_state_e;

  // Bytes that cannot appear literally inside a packet body.
  function automatic logic is_reserved(input logic [7:0] b);
    return (b == CH_EOF) || (b == CH_SOF) || (b == CH_RLE) || (b == CH_ESC);
  endfunction

  // Lowercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/gdb_rsp_txbuf.sv
// Payload retransmission buffer: simple dual-port RAM, one write port, one
// synchronous read port (data appears the cycle after the address).
module gdb_rsp_txbuf #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Write on request, read every cycle from the presented address.
  // NOTE: the storage array has no reset; its contents are only meaningful once
  // written, and a reset would prevent mapping onto block RAM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gdb_rsp_tx.sv
// GDB RSP packet transmitter: buffers a payload, frames it as $<data>#<cs> with
// escaping and a hex checksum, and replays the buffer on NAK or ack timeout.
module gdb_rsp_tx
  import gdb_rsp_pkg::*;
#(
  parameter int BUF_DEPTH   = 256,
  parameter int RETRY_MAX   = 3,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_empty,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  input  logic       ack_valid,
  input  logic       ack_nak,
  input  logic       noack,
  output logic       busy,
  output logic       err_ovf,
  output logic       err_retry
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;  // byte counts run 0..BUF_DEPTH inclusive
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [CW-1:0] FULL    = CW'(BUF_DEPTH);
  localparam logic [RW-1:0] RTY_LIM = RW'(RETRY_MAX);
  localparam logic [31:0]   TMO_END = 32'(ACK_TIMEOUT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          esc_q, esc_d;
  logic [7:0]    cs_q, cs_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   timer_q, timer_d;
  logic          noack_q, noack_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_retry_q, err_retry_d;

  logic       buf_wr_en;
  logic [7:0] rd_byte;
  logic [7:0] data_byte;
  logic       beat, fire, timeout;

  // The read address is the next-state pointer, so rd_byte always holds the
  // byte at rd_ptr_q and consecutive DATA bytes go out without a bubble.
  gdb_rsp_txbuf #(.DEPTH(BUF_DEPTH), .ADDR_W(AW)) u_buf (
    .clk       (clk),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (wr_cnt_q[AW-1:0]),
    .wr_data_i (in_data),
    .rd_addr_i (rd_ptr_d[AW-1:0]),
    .rd_data_o (rd_byte)
  );

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign err_ovf   = err_ovf_q;
  assign err_retry = err_retry_q;
  assign beat      = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign timeout   = (ACK_TIMEOUT != 0) && (timer_q == TMO_END);
  assign data_byte = esc_q ? (rd_byte ^ ESC_XOR)
                           : (is_reserved(rd_byte) ? CH_ESC : rd_byte);

  // Output byte selection, decoded from the current state only.
  // NOTE: every variable assigned in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      ST_SOF:   begin out_valid = 1'b1; out_data = CH_SOF;              end
      ST_DATA:  begin out_valid = 1'b1; out_data = data_byte;           end
      ST_EOF:   begin out_valid = 1'b1; out_data = CH_EOF;              end
      ST_CS_HI: begin out_valid = 1'b1; out_data = hex_digit(cs_q[7:4]); end
      ST_CS_LO: begin out_valid = 1'b1; out_data = hex_digit(cs_q[3:0]); end
      default:  ;
    endcase
  end

  // Framing FSM next-state logic.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    esc_d       = esc_q;
    cs_d        = cs_q;
    retry_d     = retry_q;
    timer_d     = 32'd0;
    noack_d     = noack_q;
    err_ovf_d   = 1'b0;
    err_retry_d = 1'b0;
    buf_wr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (beat) begin
          if (!in_empty) begin
            if (wr_cnt_q != FULL) begin
              buf_wr_en = 1'b1;
              wr_cnt_d  = wr_cnt_q + CW'(1);
            end else begin
              err_ovf_d = 1'b1;
            end
          end
          state_d = in_last ? ST_SOF : ST_LOAD;
        end
      end
      ST_SOF: begin
        rd_ptr_d = '0;
        esc_d    = 1'b0;
        cs_d     = 8'h00;
        if (fire) state_d = (wr_cnt_q == '0) ? ST_EOF : ST_DATA;
      end
      ST_DATA: begin
        if (fire) begin
          cs_d = cs_q + out_data;
          if (!esc_q && is_reserved(rd_byte)) begin
            esc_d = 1'b1;
          end else begin
            esc_d    = 1'b0;
            rd_ptr_d = rd_ptr_q + CW'(1);
            if (rd_ptr_q + CW'(1) == wr_cnt_q) state_d = ST_EOF;
          end
        end
      end
      ST_EOF: begin
        if (fire) state_d = ST_CS_HI;
      end
      ST_CS_HI: begin
        if (fire) begin
          state_d = ST_CS_LO;
          noack_d = noack;
        end
      end
      ST_CS_LO: begin
        if (fire) begin
          if (noack_q) begin
            state_d  = ST_IDLE;
            wr_cnt_d = '0;
            retry_d  = '0;
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q + 32'd1;
        if (ack_valid && !ack_nak) begin
          state_d  = ST_IDLE;
          wr_cnt_d = '0;
          retry_d  = '0;
        end else if ((ack_valid && ack_nak) || timeout) begin
          if (retry_q == RTY_LIM) begin
            err_retry_d = 1'b1;
            state_d     = ST_IDLE;
            wr_cnt_d    = '0;
            retry_d     = '0;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = ST_SOF;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      esc_q       <= 1'b0;
      cs_q        <= 8'h00;
      retry_q     <= '0;
      timer_q     <= 32'd0;
      noack_q     <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_retry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      esc_q       <= esc_d;
      cs_q        <= cs_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      noack_q     <= noack_d;
      err_ovf_q   <= err_ovf_d;
      err_retry_q <= err_retry_d;
    end
  end

endmodule
